pwm_sample_feeder: RTL

Upstream stage of the 8-bit PWM DAC (dac_1). It buffers 8-bit samples from a producer through a valid/ready FIFO. It presents one held sample on digital_value per sample interval, and updates it only at PWM period boundaries (256 clk) so the DAC never sees a mid-period change. It primes the FIFO before starting, tracks underruns, and drives its output to zero when disabled.

---
 rtl/pwm_sample_feeder.sv | 108 ++++++++++
 1 files changed

// File: rtl/pwm_sample_feeder.sv
// Sample feeder for the 8-bit PWM DAC: buffers producer samples in a FIFO and
// updates digital_value only on PWM period boundaries, once per sample interval.
//
// state | meaning
// IDLE  | disabled; FIFO flushed, counters and digital_value held at 0
// PRIME | accepting samples until PRIME_LEVEL entries are buffered
// RUN   | playback; head popped into digital_value on each sample_tick
module pwm_sample_feeder #(
  parameter int DEPTH          = 16,
  parameter int PRIME_LEVEL    = 4,
  parameter int SAMPLE_PERIODS = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [7:0]             s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [7:0]             digital_value,
  output logic                   sample_tick,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   underrun,
  input  logic                   underrun_clr
);

  localparam int PW  = $clog2(DEPTH);
  localparam int LW  = PW + 1;
  localparam int PCW = (SAMPLE_PERIODS > 1) ? $clog2(SAMPLE_PERIODS) : 1;
  localparam logic [PCW-1:0] LAST_PERIOD = PCW'(SAMPLE_PERIODS - 1);

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t          state, state_nx;
  logic [7:0]      mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [7:0]      phase;
  logic [PCW-1:0]  period;
  logic            push, pop, flush, fifo_empty;
  logic [LW-1:0]   level_nx;

  always_comb begin
    state_nx    = state;
    pop         = 1'b0;
    fifo_empty  = (fifo_level == '0);
    sample_tick = (state == RUN) && (phase == 8'hFF) && (period == LAST_PERIOD);
    case (state)
      IDLE:  if (enable) state_nx = PRIME;
      PRIME: if (fifo_level >= LW'(PRIME_LEVEL)) begin
               state_nx = RUN;
               pop      = 1'b1;
             end
      RUN:   if (sample_tick && !fifo_empty) pop = 1'b1;
      default: state_nx = IDLE;
    endcase
    // Disable wins everywhere: flush on the next edge and refuse the pending word.
    if (!enable) begin
      state_nx = IDLE;
      pop      = 1'b0;
    end
    flush    = !enable || (state == IDLE);
    push     = s_valid && s_ready && enable;
    level_nx = flush ? '0 : fifo_level + LW'(push) - LW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      fifo_level    <= '0;
      s_ready       <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      digital_value <= 8'h00;
      phase         <= 8'h00;
      period        <= '0;
      underrun      <= 1'b0;
    end else begin
      state      <= state_nx;
      fifo_level <= level_nx;
      // Registered from next-state values so it never depends on s_valid.
      s_ready    <= (state_nx != IDLE) && (level_nx < LW'(DEPTH));
      if (flush) begin
        wr_ptr        <= '0;
        rd_ptr        <= '0;
        digital_value <= 8'h00;
        phase         <= 8'h00;
        period        <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop) begin
          digital_value <= mem[rd_ptr];
          rd_ptr        <= rd_ptr + PW'(1);
        end
        if (state == RUN) begin
          phase <= phase + 8'd1;
          if (phase == 8'hFF)
            period <= (period == LAST_PERIOD) ? '0 : period + PCW'(1);
        end
      end
      if (sample_tick && fifo_empty) underrun <= 1'b1;
      else if (underrun_clr)         underrun <= 1'b0;
    end
  end

endmodule
